// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 request port between the I-cache and
// the D-cache. One requester owns the port at a time. Its line address and
// write flag are latched at grant and held on the L2 port until L2 acks.
// The owner then gets a one-cycle done pulse.
//
// Build option: define ARB_DATA_PRIO_EN to give the D-side fixed priority on
// ties. Without it, ties alternate round-robin starting with the I-side.
module l2_port_arbiter #(
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_add,
  output logic              i_gnt,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_add,
  input  logic              d_we,
  output logic              d_gnt,
  output logic              d_done,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_add,
  output logic              l2_we,
  input  logic              l2_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants,
  output logic [CNT_W-1:0]  stalls
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t state;

  // High when the D-side owns the current transaction.
  logic owner_d;

  // High when the I-side wins the next tie (the I-side was not granted last).
  logic rr_i_first;

  logic any_req;
  logic pick_d;

  assign any_req = i_req | d_req;

  // Winner selection: a lone request always wins. A tie goes to the D-side
  // under data priority, otherwise to whichever side was not granted last.
  always_comb begin
    pick_d = 1'b0;
    if (d_req && !i_req) begin
      pick_d = 1'b1;
    end else if (d_req && i_req) begin
`ifdef ARB_DATA_PRIO_EN
      pick_d = 1'b1;
`else
      pick_d = !rr_i_first;
`endif
    end
  end

  // Arbitration FSM: grant in IDLE, hold the L2 port in WAIT until ack.
  // Every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner_d    <= 1'b0;
      rr_i_first <= 1'b1;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      l2_req     <= 1'b0;
      l2_add     <= '0;
      l2_we      <= 1'b0;
      busy       <= 1'b0;
      i_grants   <= '0;
      d_grants   <= '0;
      stalls     <= '0;
    end else begin
      i_gnt  <= 1'b0;
      d_gnt  <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_d    <= pick_d;
            rr_i_first <= pick_d;
            l2_req     <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_WAIT;
            if (pick_d) begin
              l2_add   <= d_add;
              l2_we    <= d_we;
              d_gnt    <= 1'b1;
              d_grants <= d_grants + CNT_W'(1);
            end else begin
              l2_add   <= i_add;
              l2_we    <= 1'b0;
              i_gnt    <= 1'b1;
              i_grants <= i_grants + CNT_W'(1);
            end
          end else begin
            l2_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (any_req) begin
            stalls <= stalls + CNT_W'(1);
          end
          if (l2_ack) begin
            l2_req <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
            if (owner_d) begin
              d_done <= 1'b1;
            end else begin
              i_done <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          l2_req <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Testbench for l2_port_arbiter. A transaction-level model predicts every
// output. One compare process checks the DUT against the model each cycle.
// Directed tests add literal expectations that pin the model itself.
// Honours ARB_DATA_PRIO_EN the same way the design does.
module tb_l2_port_arbiter;

  localparam int ADDR_W = 26;
  localparam int CNT_W  = 32;
`ifdef ARB_DATA_PRIO_EN
  localparam bit PRIO_D = 1'b1;
`else
  localparam bit PRIO_D = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_add;
  logic              i_gnt;
  logic              i_done;
  logic              d_req;
  logic [ADDR_W-1:0] d_add;
  logic              d_we;
  logic              d_gnt;
  logic              d_done;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_add;
  logic              l2_we;
  logic              l2_ack;
  logic              busy;
  logic [CNT_W-1:0]  i_grants;
  logic [CNT_W-1:0]  d_grants;
  logic [CNT_W-1:0]  stalls;

  int total = 0;
  int bad   = 0;

  l2_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_add(i_add), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_add(d_add), .d_we(d_we), .d_gnt(d_gnt), .d_done(d_done),
    .l2_req(l2_req), .l2_add(l2_add), .l2_we(l2_we), .l2_ack(l2_ack),
    .busy(busy), .i_grants(i_grants), .d_grants(d_grants), .stalls(stalls)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit              m_in_txn   = 1'b0;
  bit              m_owner_d  = 1'b0;
  bit              m_last_d   = 1'b1;
  bit              m_pick_d;
  logic [ADDR_W-1:0] m_add    = '0;
  bit              m_we       = 1'b0;
  bit              m_i_gnt    = 1'b0;
  bit              m_d_gnt    = 1'b0;
  bit              m_i_done   = 1'b0;
  bit              m_d_done   = 1'b0;
  logic [CNT_W-1:0] m_i_grants = '0;
  logic [CNT_W-1:0] m_d_grants = '0;
  logic [CNT_W-1:0] m_stalls   = '0;

  // The model sees a transaction as "port busy with one owner".
  // Each edge either starts one transaction, or counts a waiting request and
  // possibly retires the current one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_txn = 0; m_owner_d = 0; m_last_d = 1; m_add = '0; m_we = 0;
      m_i_gnt = 0; m_d_gnt = 0; m_i_done = 0; m_d_done = 0;
      m_i_grants = '0; m_d_grants = '0; m_stalls = '0;
    end else begin
      m_i_gnt = 0; m_d_gnt = 0; m_i_done = 0; m_d_done = 0;
      if (!m_in_txn && (i_req || d_req)) begin
        if (i_req && d_req) m_pick_d = PRIO_D ? 1'b1 : !m_last_d;
        else                m_pick_d = d_req;
        m_last_d  = m_pick_d;
        m_owner_d = m_pick_d;
        m_in_txn  = 1;
        m_add     = m_pick_d ? d_add : i_add;
        m_we      = m_pick_d ? d_we : 1'b0;
        if (m_pick_d) begin m_d_gnt = 1; m_d_grants = m_d_grants + 1; end
        else          begin m_i_gnt = 1; m_i_grants = m_i_grants + 1; end
      end else begin
        if (i_req || d_req) m_stalls = m_stalls + 1;
        if (m_in_txn && l2_ack) begin
          m_in_txn = 0;
          if (m_owner_d) m_d_done = 1; else m_i_done = 1;
        end
      end
    end
  end

  // Compare every output against the model shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    check_output("i_gnt",    32'(i_gnt),    32'(m_i_gnt));
    check_output("d_gnt",    32'(d_gnt),    32'(m_d_gnt));
    check_output("i_done",   32'(i_done),   32'(m_i_done));
    check_output("d_done",   32'(d_done),   32'(m_d_done));
    check_output("l2_req",   32'(l2_req),   32'(m_in_txn));
    check_output("busy",     32'(busy),     32'(m_in_txn));
    check_output("l2_add",   32'(l2_add),   32'(m_add));
    check_output("l2_we",    32'(l2_we),    32'(m_we));
    check_output("i_grants", i_grants,      m_i_grants);
    check_output("d_grants", d_grants,      m_d_grants);
    check_output("stalls",   stalls,        m_stalls);
  end

  // ---------------- L2 responder ----------------
  bit auto_ack  = 1'b1;
  int ack_delay = 0;
  int ack_cnt   = 0;

  // Acks ack_delay cycles after the request is first seen, when enabled.
  initial begin
    l2_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        if (l2_req && !l2_ack) begin
          if (ack_cnt == ack_delay) begin
            l2_ack  = 1'b1;
            ack_cnt = 0;
          end else begin
            ack_cnt++;
          end
        end else begin
          l2_ack = 1'b0;
          if (!l2_req) ack_cnt = 0;
        end
      end
    end
  end

  // ---------------- grant order recorder ----------------
  bit rec_en = 1'b0;
  int order[$];

  always @(negedge clk) begin
    if (rec_en) begin
      if (i_gnt) order.push_back(0);
      if (d_gnt) order.push_back(1);
    end
  end

  // Requester agent: raise req, drop it on gnt, re-raise on done.
  // Must be called on a falling edge. lat is the number of falling edges
  // from seeing gnt to seeing done on the last transaction.
  task automatic apply_stimulus(input bit side, input logic [ADDR_W-1:0] addr,
                                input bit we, input int n, output int lat);
    int t;
    lat = 0;
    for (int k = 0; k < n; k++) begin
      if (side) begin d_req = 1'b1; d_add = addr; d_we = we; end
      else      begin i_req = 1'b1; i_add = addr; end
      t = 0;
      do begin @(negedge clk); t++; end while (!(side ? d_gnt : i_gnt) && t < 300);
      if (!(side ? d_gnt : i_gnt)) begin
        report_timeout(side ? "d_gnt_wait" : "i_gnt_wait");
        if (side) d_req = 1'b0; else i_req = 1'b0;
        return;
      end
      if (side) d_req = 1'b0; else i_req = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!(side ? d_done : i_done) && t < 300);
      if (!(side ? d_done : i_done)) begin
        report_timeout(side ? "d_done_wait" : "i_done_wait");
        return;
      end
      lat = t;
    end
  endtask

  int lat_i;
  int lat_d;
  int exp_order[5];

  // Directed test sequence.
  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_add = '0; d_add = '0;
    repeat (2) @(negedge clk);

    // Reset values.
    check_output("rst_l2_req",   32'(l2_req), 32'd0);
    check_output("rst_busy",     32'(busy),   32'd0);
    check_output("rst_l2_add",   32'(l2_add), 32'd0);
    check_output("rst_i_grants", i_grants,    32'd0);
    check_output("rst_stalls",   stalls,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single I read, ack three cycles after the grant is seen.
    ack_delay = 2;
    apply_stimulus(1'b0, 26'h0ABCDE, 1'b0, 1, lat_i);
    check_output("i_read_done",   32'(i_done), 32'd1);
    check_output("i_read_add",    32'(l2_add), 32'h0ABCDE);
    check_output("i_read_we",     32'(l2_we),  32'd0);
    check_output("i_read_grants", i_grants,    32'd1);
    check_output("i_read_lat",    32'(lat_i),  32'd3);

    // D write-back, ack in the first WAIT cycle.
    @(negedge clk);
    ack_delay = 0;
    apply_stimulus(1'b1, 26'h3FFFFFF, 1'b1, 1, lat_d);
    check_output("d_wb_done",   32'(d_done), 32'd1);
    check_output("d_wb_we",     32'(l2_we),  32'd1);
    check_output("d_wb_add",    32'(l2_add), 32'h3FFFFFF);
    check_output("d_wb_grants", d_grants,    32'd1);
    check_output("d_wb_lat",    32'(lat_d),  32'd1);

    // Reset in the middle of a transaction.
    auto_ack = 1'b0;
    l2_ack = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_add = 26'h155555;
    @(negedge clk);
    check_output("mid_gnt", 32'(i_gnt), 32'd1);
    i_req = 1'b0;
    @(negedge clk);
    check_output("mid_l2_req_pre", 32'(l2_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_output("mid_rst_l2_req", 32'(l2_req), 32'd0);
    check_output("mid_rst_busy",   32'(busy),   32'd0);
    check_output("mid_rst_i_cnt",  i_grants,    32'd0);
    check_output("mid_rst_d_cnt",  d_grants,    32'd0);
    check_output("mid_rst_stalls", stalls,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_rst_done", 32'({i_done, d_done}), 32'd0);
    auto_ack = 1'b1;

    // Simultaneous requests: I re-raises twice, D three times.
    ack_delay = 1;
    @(negedge clk);
    order.delete();
    rec_en = 1'b1;
    fork
      apply_stimulus(1'b0, 26'h000111, 1'b0, 2, lat_i);
      apply_stimulus(1'b1, 26'h000222, 1'b0, 3, lat_d);
    join
    rec_en = 1'b0;
    if (PRIO_D) exp_order = '{1, 1, 1, 0, 0};
    else        exp_order = '{0, 1, 0, 1, 1};
    check_output("order_len", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) check_output($sformatf("order_%0d", k), 32'(order[k]), 32'(exp_order[k]));
    end
    check_output("tie_stalls_seen", 32'(stalls != 0), 32'd1);
    check_output("tie_i_grants", i_grants, 32'd2);
    check_output("tie_d_grants", d_grants, 32'd3);

    // Counter wrap: preload d_grants to all ones, then one D grant.
    @(negedge clk);
    force dut.d_grants = 32'hFFFFFFFF;
    m_d_grants = 32'hFFFFFFFF;
    #1 release dut.d_grants;
    @(negedge clk);
    apply_stimulus(1'b1, 26'h00000FF, 1'b0, 1, lat_d);
    check_output("wrap_d_grants", d_grants, 32'd0);

    // Stray ack while idle: no done, no state change.
    auto_ack = 1'b0;
    @(negedge clk);
    l2_ack = 1'b1;
    @(negedge clk);
    l2_ack = 1'b0;
    check_output("stray_done",  32'({i_done, d_done}), 32'd0);
    check_output("stray_busy",  32'(busy),   32'd0);
    check_output("stray_req",   32'(l2_req), 32'd0);
    @(negedge clk);
    check_output("stray_done2", 32'({i_done, d_done}), 32'd0);
    check_output("stray_cnt",   d_grants,    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single next-level (L2) request port between the instruction cache and the data cache.
- Grants one requester at a time and holds the latched 26-bit line address and write flag on the L2 port until L2 acknowledges.
- Returns a one-cycle completion pulse to the owner.
- Keeps per-requester grant counters for the statistics module.

Parameters:
- ADDR_W, 26, line-address width (matches cache add_out).
- CNT_W, 32, width of grant/stall statistics counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  instruction cache requests L2 access
- i_add  input  ADDR_W  instruction cache line address
- i_gnt  output  1  one-cycle grant pulse to instruction cache
- i_done  output  1  one-cycle completion pulse to instruction cache
- d_req  input  1  data cache requests L2 access
- d_add  input  ADDR_W  data cache line address
- d_we  input  1  1 = write-back (evict dirty line), 0 = read fill
- d_gnt  output  1  one-cycle grant pulse to data cache
- d_done  output  1  one-cycle completion pulse to data cache
- l2_req  output  1  request valid to L2
- l2_add  output  ADDR_W  latched line address to L2
- l2_we  output  1  latched write flag to L2 (always 0 for I-side)
- l2_ack  input  1  L2 completion, single-cycle pulse
- busy  output  1  high in WAIT
- i_grants  output  CNT_W  count of I-side grants
- d_grants  output  CNT_W  count of D-side grants
- stalls  output  CNT_W  cycles in which some request was pending but not granted

Behaviour:
- Reset (async, rst_n low): state=IDLE, all pulse outputs 0, l2_req=0, l2_add=0, l2_we=0, busy=0, counters=0, rr pointer=I (I wins first tie). Release is synchronous to clk.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM has two states: IDLE and WAIT.
- IDLE, rising edge k, with i_req or d_req sampled high:
  - Pick a winner.
  - Latch its address into l2_add; l2_we=d_we for D, 0 for I.
  - Set l2_req=1, busy=1.
  - Pulse the winner's gnt for cycle k+1 only.
  - Increment the winner's grant counter.
  - Go to WAIT.
- IDLE with no request: outputs unchanged, l2_req=0.
- Round-robin when both requests are high: the winner is the side not granted last. rr pointer updates on every grant. A single request always wins.
- WAIT:
  - l2_req, l2_add and l2_we stay stable.
  - On l2_ack sampled high at edge m: l2_req=0, busy=0, owner's done pulses in cycle m+1, return to IDLE.
  - The earliest next grant is edge m+1, so there is one dead cycle between transactions.
- l2_ack in the first WAIT cycle (same cycle l2_req first seen by L2) is accepted.
- l2_ack while in IDLE is ignored; no done pulse.
- Requester protocol:
  - req is held until gnt is seen. req may drop the cycle after gnt.
  - The requester must not re-raise req before its done.
  - Address is sampled only at grant.
  - A req dropped before grant is simply not served; no error is raised.
- A new request arriving while in WAIT is held pending. It is arbitrated on return to IDLE.
- stalls increments each cycle where (i_req|d_req) is high and no grant is issued that edge, including all WAIT cycles with a pending non-owner request.
- Counters wrap modulo 2^CNT_W. There is no saturation.
- Reset mid-transaction aborts immediately: l2_req drops asynchronously and no done pulse is issued.

Optional Feature:
- ARB_DATA_PRIO_EN defined: fixed priority, D wins every tie. The rr pointer is still tracked but ignored. Preferred for write-back-heavy traces.
- Not defined: round-robin as above.
- The grant counters and stalls behave identically in both modes.

Test Plan:
1. Reset → assert rst_n=0 mid-WAIT with l2_req=1 → l2_req, busy, all counters read 0 immediately; after release, idle with no pulses.
2. Single I read → i_req=1, i_add=26'h0ABCDE, L2 acks 3 cycles later → i_gnt one cycle, l2_add=26'h0ABCDE, l2_we=0, i_done one cycle after ack, i_grants=1.
3. Simultaneous requests, round-robin → i_req=d_req=1 from reset, each re-raised after its done → grant order I, D, I, D; stalls counts the waiting cycles (≥1 per wait).
4. Same stimulus with ARB_DATA_PRIO_EN → grant order D, D, D while d_req keeps re-raising; i_grants=0 until d_req idles.
5. D write-back → d_req=1, d_we=1, d_add=26'h3FFFFFF, ack in first WAIT cycle → l2_we=1, d_done two cycles after grant edge, d_grants=1.
6. Counter wrap and stray ack → preload d_grants to 32'hFFFFFFFF via force, one D grant → d_grants=0; then pulse l2_ack in IDLE → no done pulse, no state change.
